// File: rtl/bram_to_median_window_controller.sv
// Sequencer that paces a K x K median-window engine over a BRAM-resident
// matrix: preload, per-column enables, row gaps and an inter-matrix gap.
module bram_to_median_window_controller #(
  parameter int unsigned WIN       = 5,
  parameter int unsigned OUT_COLS  = 5,
  parameter int unsigned OUT_ROWS  = 5,
  parameter int unsigned INIT_DLY  = 63,
  parameter int unsigned ROW_DLY   = 4,
  parameter int unsigned FRAME_DLY = 40
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_continuous,
  input  logic                          i_stall,
  input  logic                          i_abort,
  output logic [2:0]                    o_state,
  output logic                          o_enable,
  output logic                          o_first_col,
  output logic [$clog2(OUT_COLS)-1:0]   o_col_idx,
  output logic [$clog2(OUT_ROWS+1)-1:0] o_row_idx,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic [2:0]                    o_win
);

  localparam int unsigned MAX_A = (INIT_DLY > ROW_DLY) ? INIT_DLY : ROW_DLY;
  localparam int unsigned MAX_B = (FRAME_DLY > OUT_COLS) ? FRAME_DLY : OUT_COLS;
  localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_D) + 1;
  localparam int unsigned CLW   = $clog2(OUT_COLS);
  localparam int unsigned RW    = $clog2(OUT_ROWS + 1);

  localparam logic [CW-1:0]  INIT_LAST  = CW'(INIT_DLY - 1);
  localparam logic [CW-1:0]  ROW_LAST   = CW'(ROW_DLY - 1);
  localparam logic [CW-1:0]  FRAME_LAST = CW'(FRAME_DLY - 1);
  localparam logic [CLW-1:0] COL_LAST   = CLW'(OUT_COLS - 1);
  localparam logic [RW-1:0]  ROWS_END   = RW'(OUT_ROWS);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRELOAD      = 3'd1,
    ST_EN_FIRST_COL = 3'd2,
    ST_EN_COL       = 3'd3,
    ST_EN_NEW_ROW   = 3'd4,
    ST_WAIT_MATRIX  = 3'd5
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [CLW-1:0] r_col;
  logic [RW-1:0]  r_row;

  state_t         w_state_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [CLW-1:0] w_col_nxt;
  logic [RW-1:0]  w_row_nxt;
  logic [RW-1:0]  w_row_inc;

  // State, delay counter and index registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next-state and counter/index update; abort beats stall beats normal flow
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_row_inc   = RW'(r_row + 1'b1);
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
    end else if (!i_stall) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_PRELOAD;
            w_cnt_nxt   = '0;
          end
        end
        ST_PRELOAD: begin
          if (r_cnt == INIT_LAST) begin
            w_state_nxt = ST_EN_FIRST_COL;
            w_cnt_nxt   = '0;
            w_col_nxt   = '0;
          end else begin
            w_cnt_nxt = CW'(r_cnt + 1'b1);
          end
        end
        ST_EN_FIRST_COL: begin
          w_state_nxt = ST_EN_COL;
          w_col_nxt   = CLW'(1);
        end
        ST_EN_COL: begin
          if (r_col == COL_LAST) begin
            w_state_nxt = ST_EN_NEW_ROW;
            w_col_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_col_nxt = CLW'(r_col + 1'b1);
          end
        end
        ST_EN_NEW_ROW: begin
          if (r_cnt == ROW_LAST) begin
            w_cnt_nxt   = '0;
            w_row_nxt   = w_row_inc;
            w_state_nxt = (w_row_inc == ROWS_END) ? ST_WAIT_MATRIX : ST_EN_FIRST_COL;
          end else begin
            w_cnt_nxt = CW'(r_cnt + 1'b1);
          end
        end
        ST_WAIT_MATRIX: begin
          if (r_cnt == FRAME_LAST) begin
            w_cnt_nxt   = '0;
            w_row_nxt   = '0;
            w_state_nxt = i_continuous ? ST_EN_FIRST_COL : ST_IDLE;
          end else begin
            w_cnt_nxt = CW'(r_cnt + 1'b1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      endcase
    end
  end

  // Strobes decode from registered state and are gated by stall in the same cycle
  assign o_enable     = ((r_state == ST_EN_FIRST_COL) || (r_state == ST_EN_COL)) && !i_stall;
  assign o_first_col  = (r_state == ST_EN_FIRST_COL) && !i_stall;
  assign o_frame_done = (r_state == ST_WAIT_MATRIX) && (r_cnt == '0) && !i_stall;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_state      = r_state;
  assign o_col_idx    = r_col;
  assign o_row_idx    = r_row;
  assign o_win        = 3'(WIN);

endmodule
